sar_conv_sequencer: RTL

//  Conversion sequencer for the SAR ADC; sits directly upstream of the SAR algorithm logic.

---
 rtl/sar_conv_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sar_conv_sequencer.sv
// SAR ADC conversion sequencer: sample/strobe/settle timing, result capture; SAR_SEQ_CONVCNT_EN adds a conversion counter.
// Latency: with immediate comparator decisions dout_valid rises 1+SAMPLE_CYCLES+2*NBITS edges after start is sampled.
// Backpressure: a result loaded while dout is unconsumed overwrites it and sets sticky overrun; conversions never stall.
module sar_conv_sequencer #(
   parameter int NBITS         = 8,
   parameter int SAMPLE_CYCLES = 4,
   parameter int CMP_TIMEOUT   = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cont,
   input  logic             op,
   input  logic             om,
   input  logic [NBITS-1:0] d_in,
   output logic             sample,
   output logic             sar_rst,
   output logic             sar_en,
   output logic             cmp_clk,
   output logic             busy,
   output logic [NBITS-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             overrun,
   output logic             timeout_err,
   input  logic             err_clr,
   output logic [15:0]      conv_count
);

   localparam int BW = $clog2(NBITS + 1);
   localparam int SW = $clog2(SAMPLE_CYCLES + 1);
   localparam int TW = $clog2(CMP_TIMEOUT + 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS);
   localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLE_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(CMP_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET,
      S_SAMPLE,
      S_STROBE,
      S_SETTLE
   } state_t;

   state_t        state, state_nxt;
   logic [BW-1:0] bit_cnt, bit_cnt_nxt;
   logic [SW-1:0] samp_cnt, samp_cnt_nxt;
   logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
   logic          load;
   logic          tmo_hit;

   always_comb begin
      state_nxt    = state;
      bit_cnt_nxt  = bit_cnt;
      samp_cnt_nxt = samp_cnt;
      tmo_cnt_nxt  = tmo_cnt;
      load         = 1'b0;
      tmo_hit      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start | cont) state_nxt = S_RESET;
         end
         S_RESET: begin
            bit_cnt_nxt  = '0;
            samp_cnt_nxt = '0;
            tmo_cnt_nxt  = '0;
            state_nxt    = S_SAMPLE;
         end
         S_SAMPLE: begin
            if (samp_cnt == SAMP_LAST) state_nxt = S_STROBE;
            else                       samp_cnt_nxt = samp_cnt + SW'(1);
         end
         S_STROBE: begin
            // op=om=1 is a comparator fault, not a decision
            if (op ^ om) begin
               state_nxt   = S_SETTLE;
               bit_cnt_nxt = bit_cnt + BW'(1);
               tmo_cnt_nxt = '0;
            end else if (tmo_cnt == TMO_LAST) begin
               state_nxt   = S_IDLE;
               tmo_hit     = 1'b1;
               tmo_cnt_nxt = '0;
            end else begin
               tmo_cnt_nxt = tmo_cnt + TW'(1);
            end
         end
         S_SETTLE: begin
            if (bit_cnt == BIT_LAST) begin
               load      = 1'b1;
               state_nxt = cont ? S_RESET : S_IDLE;
            end else begin
               state_nxt = S_STROBE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         bit_cnt  <= '0;
         samp_cnt <= '0;
         tmo_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         bit_cnt  <= bit_cnt_nxt;
         samp_cnt <= samp_cnt_nxt;
         tmo_cnt  <= tmo_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout        <= '0;
         dout_valid  <= 1'b0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (load) begin
            dout       <= d_in;
            dout_valid <= 1'b1;
         end else if (dout_valid & dout_ready) begin
            dout_valid <= 1'b0;
         end
         // a same-cycle set wins over err_clr
         if (load & dout_valid & ~dout_ready) overrun <= 1'b1;
         else if (err_clr)                     overrun <= 1'b0;
         if (tmo_hit)      timeout_err <= 1'b1;
         else if (err_clr) timeout_err <= 1'b0;
      end
   end

`ifdef SAR_SEQ_CONVCNT_EN
   always_ff @(posedge clk) begin
      if (rst)       conv_count <= '0;
      else if (load) conv_count <= conv_count + 16'd1;
   end
`else
   assign conv_count = 16'd0;
`endif

   assign sar_rst = (state == S_IDLE) | (state == S_RESET);
   assign busy    = (state != S_IDLE);
   assign sample  = (state == S_SAMPLE);
   assign cmp_clk = (state == S_STROBE);
   assign sar_en  = (state == S_STROBE);

endmodule
